axi_burst_splitter_ax_issue: RTL and testbench
==============================================

Name: axi_burst_splitter_ax_issue

Overview:
- Request-side companion of the burst splitter's response counters.
- Accepts one AXI AR or AW burst at a time and allocates a beat counter for it through the counters' alloc handshake.
- Re-issues the burst downstream as (len+1) single-beat transactions (len=0), each carrying the correct per-beat address for FIXED, INCR and WRAP bursts.
- The counters block later merges the single-beat responses back into one burst response per ID.

Parameters:
- AddrWidth, 32, width of ax_addr_i/ax_addr_o.
- IdWidth, 4, width of the AXI ID.
- UserWidth, 1, width of the user sideband, passed through unmodified.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ax_id_i  in  IdWidth  burst ID.
- ax_addr_i  in  AddrWidth  burst start address.
- ax_len_i  in  8  burst length minus 1.
- ax_size_i  in  3  log2 of bytes per beat.
- ax_burst_i  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ax_user_i  in  UserWidth  user sideband.
- ax_valid_i  in  1  burst request valid.
- ax_ready_o  out  1  burst request accepted.
- alloc_id_o  out  IdWidth  ID for counter allocation.
- alloc_len_o  out  8  len for counter allocation.
- alloc_req_o  out  1  counter allocation request.
- alloc_gnt_i  in  1  counter allocation grant; may be asserted independently of alloc_req_o.
- ax_id_o  out  IdWidth  beat ID.
- ax_addr_o  out  AddrWidth  beat address.
- ax_len_o  out  8  beat length, constant 0.
- ax_size_o  out  3  beat size.
- ax_burst_o  out  2  beat burst type, constant 01 (INCR).
- ax_user_o  out  UserWidth  beat user sideband.
- ax_valid_o  out  1  beat valid.
- ax_ready_i  in  1  beat ready.

Behaviour:
- FSM states: IDLE, BUSY. Reset (rst_i=1 at a clock edge) forces IDLE on that edge.
- Reset values: ax_valid_o=0, ax_ready_o=0, alloc_req_o=0. Address, size, ID and user registers are cleared to 0.
- Reset mid-burst: remaining beats are dropped, with no further valid. The counters block is reset by the same reset.
- IDLE outputs:
  - alloc_req_o = ax_valid_i.
  - alloc_id_o = ax_id_i; alloc_len_o = ax_len_i.
  - ax_ready_o = ax_valid_i & alloc_gnt_i.
  - Allocation and burst acceptance occur in the same cycle, always together.
- BUSY outputs: ax_ready_o=0 and alloc_req_o=0.
- On acceptance:
  - Register ID, size, user and burst type.
  - Beat address register loads ax_addr_i.
  - Remaining-beat counter (8 bit) loads ax_len_i.
  - Go to BUSY.
- BUSY, ax_valid_o:
  - ax_valid_o=1.
  - First beat is presented the cycle after acceptance (1-cycle latency).
  - All beat outputs stay stable while ax_valid_o & ~ax_ready_i (AXI stability rule).
- BUSY, on each handshake (ax_valid_o & ax_ready_i):
  - If remaining==0: go to IDLE.
  - Otherwise: decrement remaining and advance the address.
  - IDLE is entered for at least one cycle between bursts (one bubble); back-to-back burst acceptance is not supported.
- Address arithmetic, with B = 1<<size. All additions are modulo 2^AddrWidth.
  - FIXED: address unchanged on every beat.
  - INCR, and reserved 11 (treated as INCR): next = (addr & ~(B-1)) + B. Only the first beat may be unaligned.
  - WRAP:
    - T = B*(len+1) (len taken from the registered value); boundary = addr & ~(T-1).
    - next = addr + B; if next == boundary + T, then next = boundary.
    - Legal WRAP len is 1, 3, 7 or 15. Any other len is treated as INCR.
  - T is at most 16*128 = 2048, so a 12-bit wrap mask suffices.
- len=0: exactly one beat is issued, then IDLE.
- len=255: 256 beats are issued. The remaining counter must not underflow.
- alloc_gnt_i low while ax_valid_i is high: ax_ready_o stays 0 and the burst waits, with no internal state change.

Test Plan:
- INCR, addr 0x1002, len 3, size 2, gnt=1, ax_ready_i=1 -> alloc pulse (id, len=3) in the accept cycle; beats 0x1002, 0x1004, 0x1008, 0x100C, each with len=0 and burst=01; then IDLE.
- WRAP, addr 0x1038, len 3, size 2 -> beats 0x1038, 0x103C, 0x1030, 0x1034.
- FIXED, addr 0x2000, len 2 -> three beats, all at 0x2000. WRAP with len 2 -> INCR sequence.
- ax_valid_i=1 with alloc_gnt_i=0 for 5 cycles -> ax_ready_o=0 and no beats; gnt rises -> accepted that cycle, first beat the next cycle.
- INCR burst with ax_ready_i held 0 for 3 cycles on beat 1 -> ax_addr_o and ax_id_o stable with valid held high; the sequence then resumes unchanged.
- INCR, len 255, size 0, addr 0xFF -> 256 beats, last at 0x1FE. Assert rst_i at beat 10 -> ax_valid_o=0 the next cycle, state IDLE, no further beats.

Source files
------------

// File: rtl/axi_burst_splitter_ax_issue_if.sv
// Request-side bus of the burst splitter: incoming AR/AW burst, counter alloc handshake, outgoing single beats.
// slave is the splitter's view; master is the environment driving bursts and sinking beats.
interface axi_burst_splitter_ax_issue_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1
);
    logic [IdWidth-1:0]   ax_id_i;
    logic [AddrWidth-1:0] ax_addr_i;
    logic [7:0]           ax_len_i;
    logic [2:0]           ax_size_i;
    logic [1:0]           ax_burst_i;
    logic [UserWidth-1:0] ax_user_i;
    logic                 ax_valid_i;
    logic                 ax_ready_o;

    logic [IdWidth-1:0]   alloc_id_o;
    logic [7:0]           alloc_len_o;
    logic                 alloc_req_o;
    logic                 alloc_gnt_i;

    logic [IdWidth-1:0]   ax_id_o;
    logic [AddrWidth-1:0] ax_addr_o;
    logic [7:0]           ax_len_o;
    logic [2:0]           ax_size_o;
    logic [1:0]           ax_burst_o;
    logic [UserWidth-1:0] ax_user_o;
    logic                 ax_valid_o;
    logic                 ax_ready_i;

    modport slave (
        input  ax_id_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, ax_user_i, ax_valid_i,
        output ax_ready_o,
        output alloc_id_o, alloc_len_o, alloc_req_o,
        input  alloc_gnt_i,
        output ax_id_o, ax_addr_o, ax_len_o, ax_size_o, ax_burst_o, ax_user_o, ax_valid_o,
        input  ax_ready_i
    );

    modport master (
        output ax_id_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, ax_user_i, ax_valid_i,
        input  ax_ready_o,
        input  alloc_id_o, alloc_len_o, alloc_req_o,
        output alloc_gnt_i,
        input  ax_id_o, ax_addr_o, ax_len_o, ax_size_o, ax_burst_o, ax_user_o, ax_valid_o,
        output ax_ready_i
    );
endinterface

// File: rtl/axi_burst_splitter_ax_issue.sv
// Splits one AXI AR/AW burst into len+1 single-beat INCR transactions after allocating a response counter.
// First beat one cycle after acceptance; beats hold while ax_ready_i is low, new bursts wait for grant and IDLE.
module axi_burst_splitter_ax_issue #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    axi_burst_splitter_ax_issue_if.slave  bus
);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e state_q, state_d;

    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] addr_q;
    logic [2:0]           size_q;
    logic [UserWidth-1:0] user_q;
    logic [1:0]           burst_q;
    logic [7:0]           len_q;
    logic [7:0]           rem_q;

    logic accept;
    logic beat_hs;
    logic ax_ready;
    logic alloc_req;
    logic ax_valid;

    // Next-beat address
    logic [AddrWidth-1:0] beat_bytes;
    logic [AddrWidth-1:0] incr_next;
    logic [11:0]          wrap_span;
    logic [AddrWidth-1:0] span_ext;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] wrap_base;
    logic [AddrWidth-1:0] wrap_inc;
    logic [AddrWidth-1:0] wrap_next;
    logic                 wrap_len_ok;
    logic [AddrWidth-1:0] next_addr;

    // FSM: next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        ax_ready  = 1'b0;
        alloc_req = 1'b0;
        ax_valid  = 1'b0;
        accept    = 1'b0;
        beat_hs   = 1'b0;
        unique case (state_q)
            IDLE: begin
                alloc_req = bus.ax_valid_i;
                ax_ready  = bus.ax_valid_i & bus.alloc_gnt_i;
                accept    = ax_ready;
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                ax_valid = 1'b1;
                beat_hs  = bus.ax_ready_i;
                if (beat_hs && (rem_q == 8'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address arithmetic; the wrap span never exceeds 16 beats of 128 bytes
    always_comb begin
        beat_bytes  = AddrWidth'(1) << size_q;
        incr_next   = (addr_q & ~(beat_bytes - AddrWidth'(1))) + beat_bytes;
        wrap_span   = 12'(({8'd0, len_q[3:0]} + 12'd1) << size_q);
        span_ext    = AddrWidth'(wrap_span);
        wrap_mask   = span_ext - AddrWidth'(1);
        wrap_base   = addr_q & ~wrap_mask;
        wrap_inc    = addr_q + beat_bytes;
        wrap_next   = (wrap_inc == (wrap_base + span_ext)) ? wrap_base : wrap_inc;
        wrap_len_ok = (len_q == 8'd1) || (len_q == 8'd3) ||
                      (len_q == 8'd7) || (len_q == 8'd15);
        next_addr   = incr_next;
        unique case (burst_q)
            BurstFixed: next_addr = addr_q;
            BurstWrap:  next_addr = wrap_len_ok ? wrap_next : incr_next;
            default:    next_addr = incr_next;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            user_q  <= '0;
            burst_q <= '0;
            len_q   <= '0;
            rem_q   <= '0;
        end else if (accept) begin
            id_q    <= bus.ax_id_i;
            addr_q  <= bus.ax_addr_i;
            size_q  <= bus.ax_size_i;
            user_q  <= bus.ax_user_i;
            burst_q <= bus.ax_burst_i;
            len_q   <= bus.ax_len_i;
            rem_q   <= bus.ax_len_i;
        end else if (beat_hs && (rem_q != 8'd0)) begin
            rem_q   <= rem_q - 8'd1;
            addr_q  <= next_addr;
        end
    end

    assign bus.ax_ready_o  = ax_ready;
    assign bus.alloc_req_o = alloc_req;
    assign bus.alloc_id_o  = bus.ax_id_i;
    assign bus.alloc_len_o = bus.ax_len_i;

    assign bus.ax_valid_o  = ax_valid;
    assign bus.ax_id_o     = id_q;
    assign bus.ax_addr_o   = addr_q;
    assign bus.ax_len_o    = 8'd0;
    assign bus.ax_size_o   = size_q;
    assign bus.ax_burst_o  = BurstIncr;
    assign bus.ax_user_o   = user_q;

endmodule

// File: tb/tb_axi_burst_splitter_ax_issue.sv
// Directed bench for the burst splitter request path: vector table of bursts plus stall/reset sequences.
module tb_axi_burst_splitter_ax_issue;

    logic clk = 1'b0;
    logic rst;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    axi_burst_splitter_ax_issue_if #(.AddrWidth(32), .IdWidth(4), .UserWidth(1)) bus ();

    axi_burst_splitter_ax_issue #(.AddrWidth(32), .IdWidth(4), .UserWidth(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        user;
        int          nbeats;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic user,
                                input int n, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.user = user;
        v.nbeats = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic user);
        bus.ax_id_i    = id;
        bus.ax_addr_i  = addr;
        bus.ax_len_i   = len;
        bus.ax_size_i  = size;
        bus.ax_burst_i = burst;
        bus.ax_user_i  = user;
        bus.ax_valid_i = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_burst(v.id, v.addr, v.len, v.size, v.burst, v.user);
        bus.alloc_gnt_i = 1'b1;
        bus.ax_ready_i  = 1'b1;
        #1;
        check($sformatf("v%0d alloc_req", idx), 32'(bus.alloc_req_o), 32'd1);
        check($sformatf("v%0d alloc_id", idx), 32'(bus.alloc_id_o), 32'(v.id));
        check($sformatf("v%0d alloc_len", idx), 32'(bus.alloc_len_o), 32'(v.len));
        check($sformatf("v%0d ax_ready_o", idx), 32'(bus.ax_ready_o), 32'd1);
        check($sformatf("v%0d no beat in accept", idx), 32'(bus.ax_valid_o), 32'd0);
        @(negedge clk);
        bus.ax_valid_i  = 1'b0;
        bus.alloc_gnt_i = 1'b0;
        for (int k = 0; k < v.nbeats; k++) begin
            #1;
            check($sformatf("v%0d b%0d valid", idx, k), 32'(bus.ax_valid_o), 32'd1);
            check($sformatf("v%0d b%0d addr", idx, k), bus.ax_addr_o, v.exp[k]);
            check($sformatf("v%0d b%0d id", idx, k), 32'(bus.ax_id_o), 32'(v.id));
            check($sformatf("v%0d b%0d len", idx, k), 32'(bus.ax_len_o), 32'd0);
            check($sformatf("v%0d b%0d burst", idx, k), 32'(bus.ax_burst_o), 32'd1);
            check($sformatf("v%0d b%0d size", idx, k), 32'(bus.ax_size_o), 32'(v.size));
            check($sformatf("v%0d b%0d user", idx, k), 32'(bus.ax_user_o), 32'(v.user));
            @(negedge clk);
        end
        #1;
        check($sformatf("v%0d idle after", idx), 32'(bus.ax_valid_o), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(4'd3, 32'h1002, 8'd3, 3'd2, 2'b01, 1'b1, 4, 32'h1002, 32'h1004, 32'h1008, 32'h100C);
        vecs[1] = mk(4'd5, 32'h1038, 8'd3, 3'd2, 2'b10, 1'b0, 4, 32'h1038, 32'h103C, 32'h1030, 32'h1034);
        vecs[2] = mk(4'd7, 32'h2000, 8'd2, 3'd2, 2'b00, 1'b1, 3, 32'h2000, 32'h2000, 32'h2000, 32'h0);
        vecs[3] = mk(4'd1, 32'h1038, 8'd2, 3'd2, 2'b10, 1'b0, 3, 32'h1038, 32'h103C, 32'h1040, 32'h0);
        vecs[4] = mk(4'd4, 32'h3003, 8'd0, 3'd1, 2'b01, 1'b1, 1, 32'h3003, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(4'd6, 32'h4004, 8'd1, 3'd3, 2'b11, 1'b0, 2, 32'h4004, 32'h4008, 32'h0, 32'h0);
        vecs[6] = mk(4'd8, 32'h5008, 8'd1, 3'd3, 2'b10, 1'b1, 2, 32'h5008, 32'h5000, 32'h0, 32'h0);

        rst = 1'b1;
        drive_burst(4'd0, 32'h0, 8'd0, 3'd0, 2'b00, 1'b0);
        bus.ax_valid_i  = 1'b0;
        bus.alloc_gnt_i = 1'b0;
        bus.ax_ready_i  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset valid_o", 32'(bus.ax_valid_o), 32'd0);
        check("reset ready_o", 32'(bus.ax_ready_o), 32'd0);
        check("reset alloc_req", 32'(bus.alloc_req_o), 32'd0);
        check("reset addr_o", bus.ax_addr_o, 32'd0);
        check("reset id_o", 32'(bus.ax_id_o), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Grant withheld for 5 cycles
        @(negedge clk);
        drive_burst(4'd2, 32'h600, 8'd0, 3'd2, 2'b01, 1'b0);
        bus.alloc_gnt_i = 1'b0;
        bus.ax_ready_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("gnt stall ready_o", 32'(bus.ax_ready_o), 32'd0);
            check("gnt stall alloc_req", 32'(bus.alloc_req_o), 32'd1);
            check("gnt stall valid_o", 32'(bus.ax_valid_o), 32'd0);
            @(negedge clk);
        end
        bus.alloc_gnt_i = 1'b1;
        #1;
        check("gnt rise ready_o", 32'(bus.ax_ready_o), 32'd1);
        @(negedge clk);
        bus.ax_valid_i  = 1'b0;
        bus.alloc_gnt_i = 1'b0;
        #1;
        check("gnt first beat valid", 32'(bus.ax_valid_o), 32'd1);
        check("gnt first beat addr", bus.ax_addr_o, 32'h600);
        @(negedge clk);
        #1;
        check("gnt idle after", 32'(bus.ax_valid_o), 32'd0);

        // Downstream stall on beat 1, with a pending burst that must not be accepted
        @(negedge clk);
        drive_burst(4'd9, 32'h100, 8'd2, 3'd2, 2'b01, 1'b0);
        bus.alloc_gnt_i = 1'b1;
        bus.ax_ready_i  = 1'b1;
        @(negedge clk);
        #1;
        check("stall beat0 addr", bus.ax_addr_o, 32'h100);
        drive_burst(4'hA, 32'h900, 8'd0, 3'd2, 2'b01, 1'b0);
        @(negedge clk);
        bus.ax_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall valid held", 32'(bus.ax_valid_o), 32'd1);
            check("stall addr held", bus.ax_addr_o, 32'h104);
            check("stall id held", 32'(bus.ax_id_o), 32'd9);
            check("busy ready_o", 32'(bus.ax_ready_o), 32'd0);
            check("busy alloc_req", 32'(bus.alloc_req_o), 32'd0);
            @(negedge clk);
        end
        bus.ax_ready_i  = 1'b1;
        bus.ax_valid_i  = 1'b0;
        bus.alloc_gnt_i = 1'b0;
        #1;
        check("resume beat1 addr", bus.ax_addr_o, 32'h104);
        @(negedge clk);
        #1;
        check("resume beat2 addr", bus.ax_addr_o, 32'h108);
        check("resume beat2 id", 32'(bus.ax_id_o), 32'd9);
        @(negedge clk);
        #1;
        check("stall idle after", 32'(bus.ax_valid_o), 32'd0);

        // 256-beat burst, byte-sized beats
        @(negedge clk);
        drive_burst(4'hB, 32'hFF, 8'd255, 3'd0, 2'b01, 1'b0);
        bus.alloc_gnt_i = 1'b1;
        bus.ax_ready_i  = 1'b1;
        @(negedge clk);
        bus.ax_valid_i  = 1'b0;
        bus.alloc_gnt_i = 1'b0;
        for (int k = 0; k < 256; k++) begin
            #1;
            check($sformatf("long b%0d valid", k), 32'(bus.ax_valid_o), 32'd1);
            check($sformatf("long b%0d addr", k), bus.ax_addr_o, 32'hFF + 32'(k));
            @(negedge clk);
        end
        #1;
        check("long idle after 256", 32'(bus.ax_valid_o), 32'd0);

        // Same burst, reset at beat 10
        @(negedge clk);
        drive_burst(4'hC, 32'hFF, 8'd255, 3'd0, 2'b01, 1'b0);
        bus.alloc_gnt_i = 1'b1;
        @(negedge clk);
        bus.ax_valid_i  = 1'b0;
        bus.alloc_gnt_i = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst beat10 addr", bus.ax_addr_o, 32'h109);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst valid dropped", 32'(bus.ax_valid_o), 32'd0);
        check("rst addr cleared", bus.ax_addr_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst no more beats", 32'(bus.ax_valid_o), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
